// File: rtl/pwm_bridge_array.sv
`default_nettype none
// pwm_bridge_array: Avalon-MM array of H-bridge / servo PWM channels sharing one period counter.
// Optional watchdog enabled by defining PWM_BRIDGE_WATCHDOG_EN.
module pwm_bridge_array #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 20,
  parameter int PRE_W  = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  output logic [NUM_CH-1:0] pin_a,
  output logic [NUM_CH-1:0] pin_b,
  output logic              period_tick
);
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_PERIOD = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_PRE    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_WDOG   = ADDR_W'(3);

  logic              enable;
  logic              fault;
  logic [CNT_W-1:0]  period;
  logic [CNT_W-1:0]  cnt;
  logic [PRE_W-1:0]  prescale;
  logic [PRE_W-1:0]  pre_cnt;
  logic [NUM_CH-1:0] ch_wr;
  logic [31:0]       ch_rd [NUM_CH];
  logic [31:0]       wd_rd;
  logic [31:0]       rd_mux;
  logic              advance;
  logic              wrap;
  logic              ctrl_wr;
  logic              unused_wdata;

  assign unused_wdata = ^avs_writedata;
  assign ctrl_wr = avs_write && (avs_address == A_CTRL);
  // >= keeps the counters bounded if PERIOD/PRESCALE shrink below the running count
  assign advance = enable && (pre_cnt >= prescale);
  assign wrap    = advance && (cnt >= period);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      pre_cnt     <= '0;
      period_tick <= 1'b0;
    end else begin
      period_tick <= wrap;
      if (!enable) begin
        cnt     <= '0;
        pre_cnt <= '0;
      end else begin
        pre_cnt <= advance ? '0 : pre_cnt + 1'b1;
        if (wrap)
          cnt <= '0;
        else if (advance)
          cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable   <= 1'b0;
      period   <= '0;
      prescale <= '0;
    end else if (avs_write) begin
      case (avs_address)
        A_CTRL:   enable   <= avs_writedata[0];
        A_PERIOD: period   <= avs_writedata[CNT_W-1:0];
        A_PRE:    prescale <= avs_writedata[PRE_W-1:0];
        default:  ;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [ADDR_W-1:0] A_CH = ADDR_W'(4 + i);
    logic [CNT_W-1:0] sh_duty, ac_duty;
    logic             sh_mode, sh_dir, sh_brake;
    logic             ac_mode, ac_dir, ac_brake;
    logic             a_q, b_q, pwm;

    assign ch_wr[i] = avs_write && (avs_address == A_CH);
    assign pwm      = cnt < ac_duty;
    assign ch_rd[i] = {1'b0, sh_brake, sh_dir, sh_mode, {(28-CNT_W){1'b0}}, sh_duty};
    assign pin_a[i] = a_q;
    assign pin_b[i] = b_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sh_duty <= '0; sh_mode <= 1'b0; sh_dir <= 1'b0; sh_brake <= 1'b0;
        ac_duty <= '0; ac_mode <= 1'b0; ac_dir <= 1'b0; ac_brake <= 1'b0;
        a_q     <= 1'b0;
        b_q     <= 1'b0;
      end else begin
        if (ch_wr[i]) begin
          sh_duty  <= avs_writedata[CNT_W-1:0];
          sh_mode  <= avs_writedata[28];
          sh_dir   <= avs_writedata[29];
          sh_brake <= avs_writedata[30];
        end
        // Loading the pre-write shadow lets a write on the wrap cycle land one period later
        if (wrap || !enable) begin
          ac_duty  <= sh_duty;
          ac_mode  <= sh_mode;
          ac_dir   <= sh_dir;
          ac_brake <= sh_brake;
        end
        if (!enable || fault) begin
          a_q <= 1'b0; b_q <= 1'b0;
        end else if (ac_mode) begin
          a_q <= pwm;  b_q <= 1'b0;
        end else if (ac_brake) begin
          a_q <= 1'b1; b_q <= 1'b1;
        end else if (ac_dir) begin
          a_q <= 1'b0; b_q <= pwm;
        end else begin
          a_q <= pwm;  b_q <= 1'b0;
        end
      end
    end
  end

`ifdef PWM_BRIDGE_WATCHDOG_EN
  logic [15:0] wd_reload;
  logic [15:0] wd_cnt;
  logic        wd_wr;
  logic        fault_clr;

  assign wd_wr     = avs_write && (avs_address == A_WDOG);
  assign fault_clr = ctrl_wr && avs_writedata[1];
  assign wd_rd     = {16'h0, wd_reload};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_reload <= '0;
      wd_cnt    <= '0;
      fault     <= 1'b0;
    end else begin
      if (wd_wr)
        wd_reload <= avs_writedata[15:0];
      if (wrap && (wd_cnt != 16'h0)) begin
        wd_cnt <= wd_cnt - 1'b1;
        if ((wd_cnt == 16'h1) && (wd_reload != 16'h0))
          fault <= 1'b1;
      end
      if (fault_clr)
        fault <= 1'b0;
      if (wd_wr)
        wd_cnt <= avs_writedata[15:0];
      else if (fault_clr || (|ch_wr))
        wd_cnt <= wd_reload;
    end
  end
`else
  assign fault = 1'b0;
  assign wd_rd = '0;
`endif

  always_comb begin
    rd_mux = '0;
    if (avs_address == A_CTRL)   rd_mux[1:0] = {fault, enable};
    if (avs_address == A_PERIOD) rd_mux[CNT_W-1:0] = period;
    if (avs_address == A_PRE)    rd_mux[PRE_W-1:0] = prescale;
    if (avs_address == A_WDOG)   rd_mux = wd_rd;
    for (int i = 0; i < NUM_CH; i++)
      if (avs_address == ADDR_W'(4 + i)) rd_mux = ch_rd[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      avs_readdata <= '0;
    else if (avs_read)
      avs_readdata <= rd_mux;
  end
endmodule
`default_nettype wire

// File: tb/tb_pwm_bridge_array.sv
`default_nettype none
// Scoreboard bench for pwm_bridge_array: an elapsed-time reference model predicts pins and readback.
module tb_pwm_bridge_array;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 20;
  localparam int PRE_W  = 8;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] avs_address = '0;
  logic              avs_write = 1'b0;
  logic [31:0]       avs_writedata = '0;
  logic              avs_read = 1'b0;
  logic [31:0]       avs_readdata;
  logic [NUM_CH-1:0] pin_a, pin_b;
  logic              period_tick;

  always #5 clk = ~clk;

  pwm_bridge_array #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRE_W(PRE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .avs_address(avs_address), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_read(avs_read), .avs_readdata(avs_readdata),
    .pin_a(pin_a), .pin_b(pin_b), .period_tick(period_tick)
  );

  int compared = 0;
  int mismatched = 0;

  // Reference state: m_e is cycles elapsed since enable, modulo the full PWM period.
  bit m_en, m_fault;
  int m_per, m_pre, m_e, m_wdr, m_wd;
  int sh_duty [NUM_CH];
  int ac_duty [NUM_CH];
  bit sh_mode [NUM_CH], sh_dir [NUM_CH], sh_brk [NUM_CH];
  bit ac_mode [NUM_CH], ac_dir [NUM_CH], ac_brk [NUM_CH];

  logic [2*NUM_CH:0] pin_q [$];
  logic [31:0]       rd_q  [$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_en = 0; m_fault = 0; m_per = 0; m_pre = 0; m_e = 0; m_wdr = 0; m_wd = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      sh_duty[i] = 0; sh_mode[i] = 0; sh_dir[i] = 0; sh_brk[i] = 0;
      ac_duty[i] = 0; ac_mode[i] = 0; ac_dir[i] = 0; ac_brk[i] = 0;
    end
  endfunction

  function automatic logic [31:0] model_read(int a);
    logic [31:0] r;
    r = '0;
    if (a == 0) r = {30'h0, m_fault, m_en};
    else if (a == 1) r = m_per;
    else if (a == 2) r = m_pre;
`ifdef PWM_BRIDGE_WATCHDOG_EN
    else if (a == 3) r = m_wdr;
`endif
    else if (a >= 4 && a < 4 + NUM_CH) begin
      r = sh_duty[a-4];
      r[28] = sh_mode[a-4]; r[29] = sh_dir[a-4]; r[30] = sh_brk[a-4];
    end
    return r;
  endfunction

  function automatic void model_write(int a, logic [31:0] d);
    if (a == 0) begin
      m_en = d[0];
`ifdef PWM_BRIDGE_WATCHDOG_EN
      if (d[1]) begin m_fault = 0; m_wd = m_wdr; end
`endif
    end
    else if (a == 1) m_per = int'(d[CNT_W-1:0]);
    else if (a == 2) m_pre = int'(d[PRE_W-1:0]);
`ifdef PWM_BRIDGE_WATCHDOG_EN
    else if (a == 3) begin m_wdr = int'(d[15:0]); m_wd = m_wdr; end
`endif
    else if (a >= 4 && a < 4 + NUM_CH) begin
      sh_duty[a-4] = int'(d[CNT_W-1:0]);
      sh_mode[a-4] = d[28]; sh_dir[a-4] = d[29]; sh_brk[a-4] = d[30];
`ifdef PWM_BRIDGE_WATCHDOG_EN
      m_wd = m_wdr;
`endif
    end
  endfunction

  // Reference model: predicts what the DUT registers at each rising edge.
  always @(posedge clk) begin
    int len, c;
    bit wrap, pwm;
    logic [NUM_CH-1:0] ea, eb;
    if (reset) begin
      model_reset();
      pin_q.push_back('0);
    end else begin
      len  = (m_pre + 1) * (m_per + 1);
      c    = (m_e / (m_pre + 1)) % (m_per + 1);
      wrap = m_en && (((m_e + 1) % len) == 0);
      ea = '0; eb = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        pwm = c < ac_duty[i];
        if (m_en && !m_fault) begin
          if (ac_mode[i]) ea[i] = pwm;
          else if (ac_brk[i]) begin ea[i] = 1'b1; eb[i] = 1'b1; end
          else if (ac_dir[i]) eb[i] = pwm;
          else ea[i] = pwm;
        end
      end
      pin_q.push_back({wrap, eb, ea});
      if (avs_read) rd_q.push_back(model_read(int'(avs_address)));
      m_e = m_en ? (m_e + 1) % len : 0;
      if (wrap || !m_en)
        for (int i = 0; i < NUM_CH; i++) begin
          ac_duty[i] = sh_duty[i]; ac_mode[i] = sh_mode[i];
          ac_dir[i]  = sh_dir[i];  ac_brk[i]  = sh_brk[i];
        end
`ifdef PWM_BRIDGE_WATCHDOG_EN
      if (wrap && m_wd > 0) begin
        m_wd--;
        if (m_wd == 0 && m_wdr != 0) m_fault = 1;
      end
`endif
      if (avs_write) model_write(int'(avs_address), avs_writedata);
    end
  end

  // Monitor: pins every cycle, readdata on the cycle after each read.
  always @(posedge clk) begin
    bit was_rd;
    logic [2*NUM_CH:0] ep;
    logic [31:0] er;
    was_rd = avs_read && !reset;
    #1;
    if (pin_q.size() == 0) begin
      compared++; mismatched++;
      $display("FAIL pins: no expected entry at %0t", $time);
    end else begin
      ep = pin_q.pop_front();
      check("pins", 32'({period_tick, pin_b, pin_a}), 32'(ep));
    end
    if (was_rd) begin
      if (rd_q.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL readdata: no expected entry at %0t", $time);
      end else begin
        er = rd_q.pop_front();
        check("readdata", avs_readdata, er);
      end
    end
  end

  task automatic bus(bit wr, bit rd, int a, logic [31:0] d);
    @(negedge clk);
    avs_write = wr; avs_read = rd; avs_address = a[ADDR_W-1:0]; avs_writedata = d;
    @(negedge clk);
    avs_write = 1'b0; avs_read = 1'b0;
  endtask

  task automatic wr(int a, logic [31:0] d); bus(1'b1, 1'b0, a, d); endtask
  task automatic rd(int a); bus(1'b0, 1'b1, a, 32'h0); endtask
  task automatic idle(int n); repeat (n) @(negedge clk); endtask

  function automatic logic [31:0] ch_word(int duty, bit mode, bit dir, bit brk);
    logic [31:0] w;
    w = duty;
    w[31:CNT_W] = '0;
    w[28] = mode; w[29] = dir; w[30] = brk;
    return w;
  endfunction

  function automatic logic [31:0] rand_ch(int per);
    int duty;
    duty = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, (1 << CNT_W) - 1))
                                       : int'($urandom_range(0, per + 2));
    return ch_word(duty, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3) == 0);
  endfunction

  initial begin
    int per, a;
    idle(3);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) rd(i);

    // Motor channels, PERIOD 9, then brake written mid-period on CH1
    wr(1, 9); wr(2, 0);
    wr(4, ch_word(3, 0, 0, 0));
    wr(5, ch_word(5, 0, 1, 0));
    wr(0, 1);
    idle(27);
    wr(5, ch_word(5, 0, 1, 1));
    idle(30);
    // Duty boundaries: 0 and PERIOD+1
    wr(4, ch_word(0, 0, 0, 0));
    wr(7, ch_word(10, 0, 0, 0));
    idle(25);
    wr(0, 0); idle(3);

    // Servo with prescaler; duty change near cnt=50 applies next period
    wr(1, 99); wr(2, 1);
    wr(6, ch_word(15, 1, 1, 1));
    wr(0, 1);
    idle(98);
    wr(6, ch_word(20, 1, 0, 0));
    rd(6);
    idle(420);
    bus(1'b1, 1'b1, 6, ch_word(7, 1, 0, 0));
    rd(6);

    // Watchdog: 3 periods without writes, then clear
    wr(0, 0); wr(1, 9); wr(2, 0); wr(4, ch_word(10, 0, 0, 0)); wr(0, 1);
    wr(3, 3);
    idle(40);
    rd(0); rd(3);
    wr(0, 3);
    idle(20);
    wr(3, 0); rd(3);

    // Randomised phases
    repeat (12) begin
      per = $urandom_range(0, 20);
      wr(0, 2);
      wr(1, per); wr(2, $urandom_range(0, 3));
      for (int i = 0; i < NUM_CH; i++) wr(4 + i, rand_ch(per));
      wr(0, 1);
      repeat (40) begin
        case ($urandom_range(0, 7))
          0, 1, 2: wr(4 + $urandom_range(0, NUM_CH - 1), rand_ch(per));
          3: rd($urandom_range(0, 31));
          4: begin
            a = 4 + $urandom_range(0, NUM_CH - 1);
            bus(1'b1, 1'b1, a, rand_ch(per));
          end
          5: wr($urandom_range(4 + NUM_CH, 31), $urandom);
          6: wr($urandom_range(0, 1) ? 3 : 0, $urandom_range(0, 1) ? $urandom_range(0, 4) : 3);
          default: idle($urandom_range(1, 8));
        endcase
      end
    end

    // Asynchronous reset while CH0 is held high
    wr(0, 2); wr(1, 9); wr(2, 0); wr(4, ch_word(10, 0, 0, 0)); wr(0, 1);
    idle(5);
    reset = 1'b1;
    #1;
    check("async_reset_pins", 32'({period_tick, pin_b, pin_a}), 32'h0);
    idle(2);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) rd(i);
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
`default_nettype wire
